// File: rtl/mul_share_ctrl_pkg.sv
// Shared types and constants for the shared-multiplier controller.
package mul_share_ctrl_pkg;

    localparam int MUL_W = 16;

    // Requester identifiers; also the encoding of rsp_id and last_grant.
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Operands held stable on the multiplier inputs while it settles.
    typedef struct packed {
        logic             id;
        logic [MUL_W-1:0] x;
        logic [MUL_W-1:0] y;
    } op_t;

    // Captured result presented on the response channel.
    typedef struct packed {
        logic             id;
        logic             cout;
        logic [MUL_W-1:0] z;
    } rsp_t;

endpackage

// File: rtl/BoothMultiplier.sv
// Behavioural stand-in for the existing combinational signed 16x16 Booth
// multiplier: z is the low 16 bits of the signed product, cout is bit 16.
module BoothMultiplier (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [15:0] z,
    output logic        cout
);

    // The low 17 bits of a signed product only depend on the low 17 bits of
    // the sign-extended operands, so a 17-bit multiply is sufficient.
    logic [16:0] prod;

    assign prod = {x[15], x} * {y[15], y};
    assign z    = prod[15:0];
    assign cout = prod[16];

endmodule

// File: rtl/mul_rr_arbiter.sv
// Two-way round-robin arbiter: a lone requester always wins; on a tie the
// requester that did not win last time is granted.
module mul_rr_arbiter
    import mul_share_ctrl_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    output logic grant0_o,
    output logic grant1_o,
    output logic grant_id_o
);

    // Grant selection from current valids and the previous winner.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant0_o = 1'b0;
        grant1_o = 1'b0;
        if (valid0_i && valid1_i) begin
            if (last_grant_i == REQ0) begin
                grant1_o = 1'b1;
            end else begin
                grant0_o = 1'b1;
            end
        end else begin
            grant0_o = valid0_i;
            grant1_o = valid1_i;
        end
        grant_id_o = grant1_o ? REQ1 : REQ0;
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one combinational multiplier between two requesters: arbitrates,
// holds the granted operands for SETTLE_CYCLES, captures the product and
// returns it on a valid/ready channel tagged with the owner's id.
module mul_share_ctrl
    import mul_share_ctrl_pkg::*;
#(
    // Cycles the operands are held before capture; legal range 1..15.
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [MUL_W-1:0] req0_x,
    input  logic [MUL_W-1:0] req0_y,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [MUL_W-1:0] req1_x,
    input  logic [MUL_W-1:0] req1_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [MUL_W-1:0] rsp_z,
    output logic             rsp_cout
);

    localparam logic [3:0] COUNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    op_t         op_q, op_d;
    rsp_t        rsp_q, rsp_d;
    logic        last_grant_q, last_grant_d;

    logic             grant0, grant1, grant_id;
    logic [MUL_W-1:0] mul_z;
    logic             mul_cout;

    mul_rr_arbiter u_arb (
        .valid0_i     (req0_valid),
        .valid1_i     (req1_valid),
        .last_grant_i (last_grant_q),
        .grant0_o     (grant0),
        .grant1_o     (grant1),
        .grant_id_o   (grant_id)
    );

    // The multiplier only ever sees the registered operands.
    BoothMultiplier u_mul (
        .x    (op_q.x),
        .y    (op_q.y),
        .z    (mul_z),
        .cout (mul_cout)
    );

    // State, counter, operand and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            op_q         <= '0;
            rsp_q        <= '0;
            last_grant_q <= REQ1;  // requester 0 wins the first tie
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q      <= state_d;
            count_q      <= count_d;
            op_q         <= op_d;
            rsp_q        <= rsp_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state and handshake outputs of the IDLE -> EVAL -> DONE sequence.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        op_d         = op_q;
        rsp_d        = rsp_q;
        last_grant_d = last_grant_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp_valid    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Readies are masked while reset is held so nothing looks accepted.
                req0_ready = grant0 & reset_n;
                req1_ready = grant1 & reset_n;
                // A grant implies the matching valid, so grant == accept here.
                if (grant0 || grant1) begin
                    op_d.id      = grant_id;
                    op_d.x       = (grant_id == REQ1) ? req1_x : req0_x;
                    op_d.y       = (grant_id == REQ1) ? req1_y : req0_y;
                    last_grant_d = grant_id;
                    count_d      = COUNT_INIT;
                    state_d      = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    rsp_d.id   = op_q.id;
                    rsp_d.z    = mul_z;
                    rsp_d.cout = mul_cout;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rsp_id   = rsp_q.id;
    assign rsp_z    = rsp_q.z;
    assign rsp_cout = rsp_q.cout;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl: a monitor pushes the reference result
// at every accept and pops/compares at every response handshake.
module tb_mul_share_ctrl;

    localparam int S_MAIN = 1;
    localparam int S_SLOW = 4;

    typedef struct {
        logic        id;
        logic [15:0] z;
        logic        cout;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;

    // Main instance (SETTLE_CYCLES=1), checked by the scoreboard monitor.
    logic        r0v, r0r, r1v, r1r, rv, rspr, rid, rc;
    logic [15:0] r0x, r0y, r1x, r1y, rz;

    // Second instance (SETTLE_CYCLES=4), checked directly.
    logic        q0v, q0r, q1v, q1r, qv, qrr, qid, qc;
    logic [15:0] q0x, q0y, q1x, q1y, qz;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    exp_t exp_q[$];
    int   acc_q[$];
    logic m_last = 1'b1;
    bit   in_rsp = 1'b0;
    logic hold_id, hold_c;
    logic [15:0] hold_z;
    int   wait0 = 0;
    int   wait1 = 0;
    logic a_id;
    int   a_cyc;
    exp_t e_cur;

    mul_share_ctrl #(.SETTLE_CYCLES(S_MAIN)) dut (
        .clk(clk), .reset_n(rst_n),
        .req0_valid(r0v), .req0_ready(r0r), .req0_x(r0x), .req0_y(r0y),
        .req1_valid(r1v), .req1_ready(r1r), .req1_x(r1x), .req1_y(r1y),
        .rsp_valid(rv), .rsp_ready(rspr), .rsp_id(rid), .rsp_z(rz), .rsp_cout(rc)
    );

    mul_share_ctrl #(.SETTLE_CYCLES(S_SLOW)) dut_slow (
        .clk(clk), .reset_n(rst_n),
        .req0_valid(q0v), .req0_ready(q0r), .req0_x(q0x), .req0_y(q0y),
        .req1_valid(q1v), .req1_ready(q1r), .req1_x(q1x), .req1_y(q1y),
        .rsp_valid(qv), .rsp_ready(qrr), .rsp_id(qid), .rsp_z(qz), .rsp_cout(qc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: signed 16x16 product, z = bits 15:0, cout = bit 16.
    function automatic exp_t model(input logic id, input logic [15:0] x, input logic [15:0] y);
        int     sx, sy;
        longint p;
        exp_t   e;
        sx = $signed(x);
        sy = $signed(y);
        p  = longint'(sx) * longint'(sy);
        e.id   = id;
        e.z    = p[15:0];
        e.cout = p[16];
        return e;
    endfunction

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: arbitration rules, accept -> push, response -> latency/hold/pop.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            m_last = 1'b1;
            in_rsp = 1'b0;
            wait0  = 0;
            wait1  = 0;
        end else begin
            check("ready_exclusive", r0r & r1r, 0);
            if (rv) check("ready_while_busy", {r0r, r1r}, 0);
            if (!r0v) wait0 = 0;
            if (!r1v) wait1 = 0;
            if ((r0v && r0r) || (r1v && r1r)) begin
                a_id = r1v && r1r;
                if (r0v && r1v) check("rr_grant", a_id, m_last ? 1'b0 : 1'b1);
                else            check("single_grant", a_id, r1v);
                if (a_id) begin
                    check("starve_bound1", wait1 <= 1, 1);
                    wait1 = 0;
                    if (r0v) wait0++;
                end else begin
                    check("starve_bound0", wait0 <= 1, 1);
                    wait0 = 0;
                    if (r1v) wait1++;
                end
                m_last = a_id;
                exp_q.push_back(a_id ? model(1'b1, r1x, r1y) : model(1'b0, r0x, r0y));
                acc_q.push_back(cyc);
            end
            if (rv) begin
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    if (acc_q.size() == 0) begin
                        check("rsp_without_accept", acc_q.size(), 1);
                    end else begin
                        a_cyc = acc_q.pop_front();
                        check("latency", cyc - a_cyc, 1 + S_MAIN);
                    end
                    hold_id = rid;
                    hold_c  = rc;
                    hold_z  = rz;
                end else begin
                    check("rsp_hold", {rid, rc, rz}, {hold_id, hold_c, hold_z});
                end
                if (rspr) begin
                    if (exp_q.size() == 0) begin
                        check("exp_queue_nonempty", exp_q.size(), 1);
                    end else begin
                        e_cur = exp_q.pop_front();
                        check("rsp_id", rid, e_cur.id);
                        check("rsp_z", rz, e_cur.z);
                        check("rsp_cout", rc, e_cur.cout);
                    end
                    in_rsp = 1'b0;
                end
            end
        end
    end

    // Directed single operation on the main instance with known constants.
    task automatic do_op(input logic id, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] ez, input logic ec);
        int   n;
        logic got;
        @(posedge clk); #1;
        if (id) begin r1v = 1'b1; r1x = x; r1y = y; end
        else    begin r0v = 1'b1; r0x = x; r0y = y; end
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            got = id ? r1r : r0r;
            n++;
        end
        check("op_accept", got, 1);
        @(posedge clk); #1;
        r0v = 1'b0; r1v = 1'b0;
        r0x = 16'($urandom); r0y = 16'($urandom);
        r1x = 16'($urandom); r1y = 16'($urandom);
        n = 0;
        @(negedge clk);
        while (!rv && n < 20) begin @(negedge clk); n++; end
        check("op_rsp_valid", rv, 1);
        check("op_rsp_id", rid, id);
        check("op_rsp_z", rz, ez);
        check("op_rsp_cout", rc, ec);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    initial begin
        int          n, k;
        logic        got, acc0, acc1;
        logic [3:0]  gseq;
        logic [15:0] sx [2];
        logic [15:0] sy [2];
        logic        sid [2];
        exp_t        se;

        r0v = 0; r1v = 0; r0x = 0; r0y = 0; r1x = 0; r1y = 0; rspr = 1;
        q0v = 0; q1v = 0; q0x = 0; q0y = 0; q1x = 0; q1y = 0; qrr = 1;
        rst_n = 1'b0;

        // Reset state, with both valids raised to tempt the readies.
        r0v = 1; r1v = 1;
        repeat (2) @(negedge clk);
        check("rst_req0_ready", r0r, 0);
        check("rst_req1_ready", r1r, 0);
        check("rst_rsp_valid", rv, 0);
        check("rst_rsp_id", rid, 0);
        check("rst_rsp_z", rz, 0);
        check("rst_rsp_cout", rc, 0);
        r0v = 0; r1v = 0;
        @(posedge clk); #1; rst_n = 1'b1;

        // Single op and overflow cases.
        do_op(1'b0, 16'h0003, 16'h0005, 16'h000F, 1'b0);
        do_op(1'b1, 16'h0100, 16'h0100, 16'h0000, 1'b1);
        do_op(1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0);

        // Both valid continuously after reset: grants alternate 0,1,0,1.
        pulse_reset();
        r0v = 1; r1v = 1; rspr = 1;
        r0x = 16'h0011; r0y = 16'h0022; r1x = 16'h0033; r1y = 16'h0044;
        gseq = '0; k = 0; n = 0;
        while (k < 4 && n < 60) begin
            @(negedge clk);
            n++;
            got = r0r | r1r;
            if (got) begin gseq[k] = r1r; k++; end
            @(posedge clk); #1;
            if (got) begin
                r0x = rand_op(); r0y = rand_op(); r1x = rand_op(); r1y = rand_op();
            end
        end
        r0v = 0; r1v = 0;
        check("arb_accepts", k, 4);
        check("arb_sequence", gseq, 4'b1010);
        repeat (6) @(posedge clk);

        // Backpressure: result held for 5 cycles, readies stay low.
        #1; rspr = 0; r0v = 1; r0x = 16'h1234; r0y = 16'h0011;
        @(negedge clk);
        check("bp_accept", r0r, 1);
        @(posedge clk); #1;
        r0v = 0; r1v = 1; r1x = 16'h0002; r1y = 16'h0003;
        n = 0;
        @(negedge clk);
        while (!rv && n < 20) begin @(negedge clk); n++; end
        check("bp_rsp_valid", rv, 1);
        check("bp_rsp_z", rz, 16'h3574);
        check("bp_rsp_cout", rc, 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_valid_held", rv, 1);
            check("bp_readys_low", {r0r, r1r}, 0);
        end
        @(posedge clk); #1; rspr = 1;
        @(negedge clk);
        @(negedge clk);
        check("bp_valid_drop", rv, 0);
        check("bp_ready_back", r1r, 1);
        @(posedge clk); #1; r1v = 0;
        repeat (6) @(posedge clk);

        // Reset during EVAL discards the operation.
        #1; r0v = 1; r0x = 16'h00AA; r0y = 16'h0003;
        @(negedge clk);
        check("rst_eval_accept", r0r, 1);
        @(posedge clk); #1;
        rst_n = 1'b0; r0v = 1; r1v = 1;
        #1;
        check("rst_eval_rsp_valid", rv, 0);
        check("rst_eval_readys", {r0r, r1r}, 0);
        repeat (2) @(negedge clk);
        check("rst_eval_no_rsp", rv, 0);
        check("rst_eval_z_cleared", rz, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        r0x = 16'h0007; r0y = 16'h0006; r1x = 16'h0005; r1y = 16'h0005;
        @(negedge clk);
        check("post_rst_first_grant", {r0r, r1r}, 2'b10);
        @(posedge clk); #1; r0v = 0; r1v = 0;
        n = 0;
        @(negedge clk);
        while (!rv && n < 20) begin @(negedge clk); n++; end
        check("post_rst_rsp_z", rz, 16'h002A);
        check("post_rst_rsp_id", rid, 0);
        repeat (4) @(posedge clk);

        // Randomized traffic with random backpressure and valid drops.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc0 = r0v & r0r;
            acc1 = r1v & r1r;
            @(posedge clk); #1;
            if (acc0 || !r0v) begin
                r0v = ($urandom_range(0, 99) < 60); r0x = rand_op(); r0y = rand_op();
            end else if ($urandom_range(0, 15) == 0) begin
                r0v = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                r0x = rand_op();
            end
            if (acc1 || !r1v) begin
                r1v = ($urandom_range(0, 99) < 60); r1x = rand_op(); r1y = rand_op();
            end else if ($urandom_range(0, 15) == 0) begin
                r1v = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                r1y = rand_op();
            end
            rspr = ($urandom_range(0, 3) != 0);
        end
        r0v = 0; r1v = 0; rspr = 1;
        repeat (10) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        // SETTLE_CYCLES=4 instance: latency and operand isolation.
        sid[0] = 1'b0; sx[0] = 16'h0007; sy[0] = 16'h0009;
        sid[1] = 1'b1; sx[1] = 16'hFFFF; sy[1] = 16'h0003;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (sid[i]) begin q1v = 1; q1x = sx[i]; q1y = sy[i]; end
            else        begin q0v = 1; q0x = sx[i]; q0y = sy[i]; end
            n = 0; got = 1'b0;
            while (!got && n < 20) begin
                @(negedge clk);
                got = sid[i] ? q1r : q0r;
                n++;
            end
            check("slow_accept", got, 1);
            se = model(sid[i], sx[i], sy[i]);
            n = 0;
            do begin
                @(posedge clk); #1;
                q0v = 0; q1v = 0;
                q0x = 16'($urandom); q0y = 16'($urandom);
                q1x = 16'($urandom); q1y = 16'($urandom);
                @(negedge clk);
                n++;
            end while (!qv && n < 20);
            check("slow_latency", n, 1 + S_SLOW);
            check("slow_rsp_id", qid, se.id);
            check("slow_rsp_z", qz, se.z);
            check("slow_rsp_cout", qc, se.cout);
        end
        check("slow_first_z_const", {16'h0, qz} == 32'd63 ? 1'b0 : 1'b1, 1);
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, actual timeout required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Sequences and shares the single 16x16 combinational BoothMultiplier datapath between two requesters, e.g. requester 0 = execute stage, requester 1 = address/microcode unit.
- Registers the granted operands and holds them stable for a programmable settle window, then captures the 16-bit product and the carry-overflow flag.
- Returns the captured result on a valid/ready response channel tagged with the requester id.
- Sits between the CPU control path and the existing multiplier instance.

Parameters:
- SETTLE_CYCLES, 1, cycles the operand registers are held before the result is captured. Legal range 1..15. Covers the multiplier's combinational CSA/RCA delay.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_x  in  16  requester 0 multiplicand
- req0_y  in  16  requester 0 multiplier
- req1_valid  in  1  requester 1 has an operation
- req1_ready  out  1  requester 1 operation accepted this cycle
- req1_x  in  16  requester 1 multiplicand
- req1_y  in  16  requester 1 multiplier
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes the result
- rsp_id  out  1  requester that owns the result
- rsp_z  out  16  low 16 bits of x*y (z16)
- rsp_cout  out  1  multiplier cout (product bit 16)

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous, active-low.
- Reset values: state=IDLE, reqN_ready=0 while in reset, rsp_valid=0, rsp_id=0, rsp_z=0, rsp_cout=0, operand regs=0, count=0, last_grant=1, so requester 0 wins first.
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - reqN_ready = grant_N combinationally. At most one ready is high.
  - Only one valid: that requester is granted.
  - Both valid: grant goes to the requester that is not last_grant (round-robin).
  - Accept = valid & ready in the same cycle.
  - On accept: latch x, y and id into the operand regs, set last_grant=id, set count=SETTLE_CYCLES-1, go to EVAL.
- EVAL:
  - Both ready outputs are 0. Operand regs drive the multiplier unchanged.
  - count>0: decrement count.
  - count==0: capture z16 into rsp_z, cout into rsp_cout, id into rsp_id. Go to DONE.
- DONE:
  - rsp_valid=1. rsp_id, rsp_z and rsp_cout stay stable until the handshake.
  - rsp_ready=1: go to IDLE next cycle.
  - No bypass: a new request can be accepted at the earliest in the cycle after the handshake.
- Latency: accept in cycle t, rsp_valid high in cycle t+1+SETTLE_CYCLES.
- Throughput: one operation per SETTLE_CYCLES+2 cycles when rsp_ready is held high.
- Requester valid deasserted without ready: no effect. The block holds no request state until accept.
- Requester x/y changing while not accepted: ignored. After accept they are ignored until the next accept.
- Starvation bound: a requester held valid is granted within 2 accepts.
- Reset asserted mid-operation: in-flight operation discarded, no response issued, all values return to reset values immediately.
- Arithmetic: no sign/width handling in the controller. rsp_z and rsp_cout are exactly the multiplier outputs for the latched operands.

Decomposition:
- Shared package/header: state encodings ST_IDLE=2'd0, ST_EVAL=2'd1, ST_DONE=2'd2; MUL_W=16; requester id constants REQ0=1'b0, REQ1=1'b1.
- Sub-module mul_rr_arbiter:
  - Combinational 2-way round-robin grant from req valids and last_grant.
  - Outputs grant0, grant1, grant_id.
- Top module holds the FSM, settle counter, operand/result registers and the BoothMultiplier instance.

Test Plan:
- Single op, SETTLE_CYCLES=1: req0 x=0x0003, y=0x0005 accepted in cycle 0 -> rsp_valid in cycle 2, rsp_z=0x000F, rsp_cout=0, rsp_id=0.
- Overflow: req1 x=0x0100, y=0x0100 -> rsp_z=0x0000, rsp_cout=1, rsp_id=1. Then x=0xFFFF, y=0xFFFF (-1*-1) -> rsp_z=0x0001, rsp_cout=0.
- Arbitration: both valid continuously after reset -> grants go 0,1,0,1. Each ready pulses for exactly one cycle, never both in the same cycle.
- Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_valid and rsp_z/rsp_id held stable, both readys stay 0. rsp_ready=1 -> rsp_valid drops next cycle, ready reasserts.
- SETTLE_CYCLES=4: accept in cycle 0 -> rsp_valid first high in cycle 5. Operand regs constant during cycles 1-4.
- Reset in EVAL: reset_n low at cycle 1 after accept -> rsp_valid=0 immediately. After release, the next response carries only the new request's data, and the first grant goes to req0.
